// File: rtl/key_pulse_pkg.sv
// Shared definitions for the key pulse generator: FSM states, key indices, default timing.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package key_pulse_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } key_state_t;

  // Bit positions of each button inside key_held and the internal press vector
  localparam int KEY_UP    = 3;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 0;

  // 20 ms debounce, 0.5 s first repeat, 0.1 s repeat period at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-FF synchroniser, debounce counter, IDLE/PRESSED FSM, optional auto-repeat (KEY_REPEAT_EN).
// Latency: press pulse is combinational in the cycle the debounced level flips (DEBOUNCE_CYCLES after sync).
// Backpressure: none; pulses are fire-and-forget.
module key_debounce
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic CLOCK50,
  input  logic reset,
  input  logic key_n,
  output logic press,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_pressed;
  logic          differs;
  logic          accept;
  logic          press_edge;
  logic [CW-1:0] cnt_q, cnt_d;
  key_state_t    state_q, state_d;

  // Two-stage synchroniser; resets to the released (high) level
  always_ff @(posedge CLOCK50 or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_n};
  end

  assign level_pressed = ~sync_q[1];
  // The FSM state doubles as the debounced level, so the flip and the transition share one edge
  assign held = (state_q == PRESSED);

  // Debounce counter and FSM next-state; counter saturates at CNT_LAST by clearing on accept
  always_comb begin
    differs    = (level_pressed != held);
    accept     = differs && (cnt_q == CNT_LAST);
    cnt_d      = '0;
    state_d    = state_q;
    press_edge = 1'b0;
    if (differs && !accept) cnt_d = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = PRESSED;
          press_edge = 1'b1;
        end
      end
      PRESSED: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter and FSM state registers
  always_ff @(posedge CLOCK50 or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_first_q;
  logic          rpt_fire;
  logic [RW-1:0] rpt_target;

  // rpt_cnt_q counts cycles since the last emitted pulse; first interval is the longer delay
  always_comb begin
    rpt_target = rpt_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
    rpt_fire   = held && !accept && (rpt_cnt_q == rpt_target);
  end

  // Repeat counter: restarts at the press pulse and at each repeat, cleared when not pressed
  always_ff @(posedge CLOCK50 or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (state_d != PRESSED) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (press_edge) begin
      rpt_cnt_q   <= RW'(1);
      rpt_first_q <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt_q   <= RW'(1);
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_q + 1'b1;
    end
  end

  assign press = press_edge | rpt_fire;
`else
  assign press = press_edge;
`endif

endmodule

// File: rtl/key_pulse_gen.sv
// Four debounced buttons to registered one-cycle move pulses; opposing pulses on an axis cancel. Repeat via KEY_REPEAT_EN.
// Latency: key_held and move_* change DEBOUNCE_CYCLES+1 edges after the first sample of a new key level.
// Backpressure: none; consumer must take each pulse in the cycle it is high.
module key_pulse_gen
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       CLOCK50,
  input  logic       reset,
  input  logic       KEY3,
  input  logic       KEY2,
  input  logic       KEY1,
  input  logic       KEY0,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [3:0] key_held
);

  logic [3:0] key_n;
  logic [3:0] press;

  assign key_n = {KEY3, KEY2, KEY1, KEY0};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_deb (
      .CLOCK50(CLOCK50),
      .reset  (reset),
      .key_n  (key_n[i]),
      .press  (press[i]),
      .held   (key_held[i])
    );
  end

  // Register move pulses; simultaneous opposing pulses on one axis cancel each other
  always_ff @(posedge CLOCK50 or negedge reset) begin
    if (!reset) begin
      move_up    <= 1'b0;
      move_down  <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      move_up    <= press[KEY_UP]    & ~press[KEY_DOWN];
      move_down  <= press[KEY_DOWN]  & ~press[KEY_UP];
      move_left  <= press[KEY_LEFT]  & ~press[KEY_RIGHT];
      move_right <= press[KEY_RIGHT] & ~press[KEY_LEFT];
    end
  end

endmodule
